multicycle_ctrl: RTL and testbench

Multi-cycle main controller for the simple CPU datapath. Sequences every instruction through fetch, decode, execute, memory and write-back states. It is the driving end of the ALU control interface: it generates `ALUctr`, operand selects and every datapath write enable. It consumes the ALU `zero` flag for branch resolution.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// The controller reads instruction fields and the ALU zero flag and drives every enable/select.
interface multicycle_ctrl_if #(
  parameter int OPW = 6,
  parameter int FNW = 6
);
  logic [OPW-1:0] op;
  logic [FNW-1:0] funct;
  logic           zero;
  logic           pc_wr;
  logic [1:0]     npc_sel;
  logic           ir_wr;
  logic           reg_wr;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           mem_wr;
  logic           alu_src;
  logic [1:0]     ext_op;
  logic [2:0]     ALUctr;
  logic [3:0]     state;

  modport master (
    input  op, funct, zero,
    output pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, mem_to_reg,
           mem_wr, alu_src, ext_op, ALUctr, state
  );

  modport slave (
    output op, funct, zero,
    input  pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, mem_to_reg,
           mem_wr, alu_src, ext_op, ALUctr, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: fetch/decode/execute/memory/write-back sequencing
// with Moore-style datapath controls; only pc_wr in BRANCH follows the live zero flag.
module multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXE_R   = 4'd6,
    S_WB_R    = 4'd7,
    S_BRANCH  = 4'd8,
    S_EXE_I   = 4'd9,
    S_WB_I    = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [FNW-1:0] FN_ADDU  = FNW'(6'b100001);
  localparam logic [FNW-1:0] FN_SUBU  = FNW'(6'b100011);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [FNW-1:0] funct_q, funct_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  // Fields are captured at DECODE so later states do not depend on the IR holding still.
  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    funct_d = funct_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        op_d    = bus.op;
        funct_d = bus.funct;
        case (bus.op)
          OP_LW, OP_SW:   state_d = S_MEM_ADR;
          OP_RTYPE:       state_d = (bus.funct == FN_ADDU || bus.funct == FN_SUBU) ? S_EXE_R : S_FETCH;
          OP_ORI, OP_LUI: state_d = S_EXE_I;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_EXE_R:   state_d = S_WB_R;
      S_EXE_I:   state_d = S_WB_I;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_wr      = 1'b0;
    bus.npc_sel    = 2'b00;
    bus.ir_wr      = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.alu_src    = 1'b0;
    bus.ext_op     = 2'b00;
    bus.ALUctr     = 3'b000;
    bus.state      = rst ? 4'd0 : state_q;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
        end
        S_MEM_ADR, S_MEM_RD: begin
          bus.alu_src = 1'b1;
          bus.ext_op  = 2'b01;
          bus.ALUctr  = 3'b010;
        end
        S_MEM_WB: begin
          bus.reg_wr     = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_wr  = 1'b1;
          bus.alu_src = 1'b1;
          bus.ext_op  = 2'b01;
          bus.ALUctr  = 3'b010;
        end
        S_EXE_R, S_WB_R: begin
          bus.ALUctr  = (funct_q == FN_SUBU) ? 3'b110 : 3'b010;
          bus.reg_wr  = (state_q == S_WB_R);
          bus.reg_dst = (state_q == S_WB_R);
        end
        S_EXE_I, S_WB_I: begin
          bus.alu_src = 1'b1;
          bus.ext_op  = (op_q == OP_LUI) ? 2'b10 : 2'b00;
          bus.ALUctr  = (op_q == OP_LUI) ? 3'b000 : 3'b001;
          bus.reg_wr  = (state_q == S_WB_I);
        end
        S_BRANCH: begin
          bus.ALUctr  = 3'b110;
          bus.npc_sel = 2'b01;
          bus.pc_wr   = bus.zero;
        end
        S_JUMP: begin
          bus.pc_wr   = 1'b1;
          bus.npc_sel = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: a per-instruction path/output table model
// predicts every cycle's outputs, a negedge process compares them.
module tb_multicycle_ctrl;

  typedef enum int {C_LW, C_SW, C_ADDU, C_SUBU, C_ORI, C_LUI, C_BEQ, C_J, C_INV} cls_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.OPW(6), .FNW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [17:0] exp_vec   = '0;
  logic        exp_valid = 1'b0;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic        pinned      = 1'b0;

  function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      6'b000000: return (f == 6'b100001) ? C_ADDU : (f == 6'b100011) ? C_SUBU : C_INV;
      default:   return C_INV;
    endcase
  endfunction

  function automatic int path_len(input cls_t c);
    case (c)
      C_LW:       return 5;
      C_BEQ, C_J: return 3;
      C_INV:      return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input cls_t c, input int k);
    logic [3:0] p [5];
    case (c)
      C_LW:           p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      C_SW:           p = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      C_ADDU, C_SUBU: p = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      C_ORI, C_LUI:   p = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
      C_BEQ:          p = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
      C_J:            p = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0};
      default:        p = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    endcase
    return p[k];
  endfunction

  // Packed as {pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, mem_to_reg, mem_wr, alu_src, ext_op, ALUctr, state}
  function automatic logic [17:0] exp_of(input logic [3:0] s, input cls_t c, input logic z);
    logic pw, iw, rw, rd, m2r, mw, as;
    logic [1:0] ns, eo;
    logic [2:0] ac;
    {pw, iw, rw, rd, m2r, mw, as} = '0;
    ns = 2'b00; eo = 2'b00; ac = 3'b000;
    case (s)
      4'd0: begin pw = 1'b1; iw = 1'b1; end
      4'd2, 4'd3: begin as = 1'b1; eo = 2'b01; ac = 3'b010; end
      4'd4: begin rw = 1'b1; m2r = 1'b1; end
      4'd5: begin mw = 1'b1; as = 1'b1; eo = 2'b01; ac = 3'b010; end
      4'd6, 4'd7: begin ac = (c == C_SUBU) ? 3'b110 : 3'b010; rw = (s == 4'd7); rd = (s == 4'd7); end
      4'd9, 4'd10: begin
        as = 1'b1;
        eo = (c == C_LUI) ? 2'b10 : 2'b00;
        ac = (c == C_LUI) ? 3'b000 : 3'b001;
        rw = (s == 4'd10);
      end
      4'd8: begin ac = 3'b110; ns = 2'b01; pw = z; end
      4'd11: begin pw = 1'b1; ns = 2'b10; end
      default: ;
    endcase
    return {pw, ns, iw, rw, rd, m2r, mw, as, eo, ac, s};
  endfunction

  wire [17:0] got_vec = {bus.pc_wr, bus.npc_sel, bus.ir_wr, bus.reg_wr, bus.reg_dst,
                         bus.mem_to_reg, bus.mem_wr, bus.alu_src, bus.ext_op, bus.ALUctr, bus.state};

  task automatic pin(input string name, input logic [17:0] got, input logic [17:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL pin_%s got %b want %b", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!pinned) begin
      pinned = 1'b1;
      pin("lw_len",  18'(path_len(classify(6'b100011, 6'b000000))), 18'd5);
      pin("sw_len",  18'(path_len(classify(6'b101011, 6'b010101))), 18'd4);
      pin("beq_len", 18'(path_len(classify(6'b000100, 6'b000000))), 18'd3);
      pin("inv_len", 18'(path_len(classify(6'b000000, 6'b100000))), 18'd2);
      pin("fetch",   exp_of(4'd0, C_INV, 1'b0), 18'b1_00_1_0_0_0_0_0_00_000_0000);
      pin("beq_z1",  exp_of(4'd8, C_BEQ, 1'b1), 18'b1_01_0_0_0_0_0_0_00_110_1000);
      pin("ori_wb",  exp_of(4'd10, C_ORI, 1'b0), 18'b0_00_0_1_0_0_0_1_00_001_1010);
    end
    if (exp_valid) begin
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL outputs cyc %0d rst %0b got %b exp %b", cyc, rst, got_vec, exp_vec);
      end
      vectors++;
      if (bus.reg_wr && bus.mem_wr) begin
        miscompares++;
        $display("FAIL wr_overlap cyc %0d got reg_wr=1 mem_wr=1 exp not both", cyc);
      end
    end
  end

  task automatic do_reset();
    repeat (2) begin
      @(posedge clk); #1;
      rst       = 1'b1;
      bus.op    = 6'($urandom);
      bus.funct = 6'($urandom);
      bus.zero  = 1'($urandom);
      exp_vec   = '0;
      exp_valid = 1'b1;
    end
  endtask

  // zmode: 0/1 force zero, 2 random every cycle; abort_at stops after that cycle index.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort_at);
    cls_t c;
    int   n;
    logic z;
    c = classify(o, f);
    n = path_len(c);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst       = 1'b0;
      bus.op    = (k == 0) ? 6'($urandom) : o;
      bus.funct = (k == 0) ? 6'($urandom) : f;
      z         = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      bus.zero  = z;
      exp_vec   = exp_of(path_state(c, k), c, z);
      exp_valid = 1'b1;
      if (k == abort_at) break;
    end
  endtask

  logic [5:0] ops [8];

  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    ops = '{6'b000000, 6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000010};

    do_reset();
    run_instr(6'b000000, 6'b100001, 2, -1);
    run_instr(6'b000000, 6'b100011, 2, -1);
    run_instr(6'b100011, 6'b000000, 2, -1);
    run_instr(6'b101011, 6'b000000, 2, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b001101, 6'b000000, 2, -1);
    run_instr(6'b001111, 6'b000000, 2, -1);
    run_instr(6'b000010, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(6'b000000, 6'b000000, 2, -1);
    run_instr(6'b100011, 6'b000000, 2, 3);
    do_reset();
    run_instr(6'b000000, 6'b100001, 2, -1);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r < 8) begin
        run_instr(ops[r], (r == 1) ? 6'b100011 : (r == 0) ? 6'b100001 : 6'($urandom), 2, -1);
      end else if (r == 8) begin
        run_instr(6'b000000, 6'($urandom), 2, -1);
      end else if (r == 9) begin
        run_instr(6'($urandom), 6'($urandom), 2, -1);
      end else if (r == 10) begin
        do_reset();
      end else begin
        run_instr(ops[$urandom_range(0, 7)], 6'b100001, 2, $urandom_range(0, 4));
        do_reset();
      end
    end

    @(posedge clk); #1;
    exp_valid = 1'b0;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
